// File: rtl/instr_decode.sv
// M-stage memory-instruction decoder: classifies the opcode as load/store/other
// and produces the data-memory write enable plus load and store sub-op codes.
module instr_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        MemWrite,
  output logic [3:0]  DMLOp,
  output logic [3:0]  DMSOp,
  output logic        load,
  output logic        store
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam logic [3:0] DML_NONE = 4'd0;
  localparam logic [3:0] DML_LW   = 4'd1;
  localparam logic [3:0] DML_LB   = 4'd2;
  localparam logic [3:0] DML_LBU  = 4'd3;
  localparam logic [3:0] DML_LH   = 4'd4;
  localparam logic [3:0] DML_LHU  = 4'd5;

  localparam logic [3:0] DMS_NONE = 4'd0;
  localparam logic [3:0] DMS_SW   = 4'd1;
  localparam logic [3:0] DMS_SH   = 4'd2;
  localparam logic [3:0] DMS_SB   = 4'd3;

  logic [5:0] opcode;
  assign opcode = instr[31:26];

  // clk, reset and the operand fields are intentionally ignored; outputs depend
  // only on the opcode so the consumer sees them in the same cycle.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, reset, instr[25:0]};

  always_comb begin
    DMLOp = DML_NONE;
    DMSOp = DMS_NONE;
    case (opcode)
      OP_LW:   DMLOp = DML_LW;
      OP_LB:   DMLOp = DML_LB;
      OP_LBU:  DMLOp = DML_LBU;
      OP_LH:   DMLOp = DML_LH;
      OP_LHU:  DMLOp = DML_LHU;
      OP_SW:   DMSOp = DMS_SW;
      OP_SH:   DMSOp = DMS_SH;
      OP_SB:   DMSOp = DMS_SB;
      default: begin
        DMLOp = DML_NONE;
        DMSOp = DMS_NONE;
      end
    endcase
  end

  // A nonzero sub-op code is the classification; this keeps load/store exclusive.
  assign load     = (DMLOp != DML_NONE);
  assign store    = (DMSOp != DMS_NONE);
  assign MemWrite = store;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed vector table, reset/operand
// independence sequences and a sweep of all 64 opcodes.
module tb_instr_decode;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        MemWrite;
  logic [3:0]  DMLOp;
  logic [3:0]  DMSOp;
  logic        load;
  logic        store;

  int checks;
  int failures;

  instr_decode dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .MemWrite (MemWrite),
    .DMLOp    (DMLOp),
    .DMSOp    (DMSOp),
    .load     (load),
    .store    (store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        load;
    logic        store;
    logic        mem_write;
    logic [3:0]  dml;
    logic [3:0]  dms;
  } vec_t;

  vec_t vecs[19];

  // Packed result order: {load, store, MemWrite, DMLOp, DMSOp}
  function automatic logic [10:0] pack_exp(input logic l, input logic s, input logic w,
                                           input logic [3:0] dl, input logic [3:0] ds);
    return {l, s, w, dl, ds};
  endfunction

  // Hand-written reference opcode map
  function automatic logic [10:0] ref_model(input logic [5:0] op);
    case (op)
      6'b100011: return pack_exp(1, 0, 0, 4'd1, 4'd0);
      6'b100000: return pack_exp(1, 0, 0, 4'd2, 4'd0);
      6'b100100: return pack_exp(1, 0, 0, 4'd3, 4'd0);
      6'b100001: return pack_exp(1, 0, 0, 4'd4, 4'd0);
      6'b100101: return pack_exp(1, 0, 0, 4'd5, 4'd0);
      6'b101011: return pack_exp(0, 1, 1, 4'd0, 4'd1);
      6'b101001: return pack_exp(0, 1, 1, 4'd0, 4'd2);
      6'b101000: return pack_exp(0, 1, 1, 4'd0, 4'd3);
      default:   return 11'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = {load, store, MemWrite, DMLOp, DMSOp};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s instr=%h got {l,s,w,dml,dms}=%b_%b_%b_%0d_%0d required=%b_%b_%b_%0d_%0d",
               name, instr, got[10], got[9], got[8], got[7:4], got[3:0],
               exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end else begin
      $display("ok   %s instr=%h l=%b s=%b w=%b dml=%0d dms=%0d",
               name, instr, load, store, MemWrite, DMLOp, DMSOp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s instr=%h got=%b required=%b", name, instr, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    instr    = 32'h0;

    vecs[0]  = '{"lw",        32'h8C080004, 1, 0, 0, 4'd1, 4'd0};
    vecs[1]  = '{"lb",        32'h80080000, 1, 0, 0, 4'd2, 4'd0};
    vecs[2]  = '{"lbu",       32'h90080000, 1, 0, 0, 4'd3, 4'd0};
    vecs[3]  = '{"lh",        32'h84080000, 1, 0, 0, 4'd4, 4'd0};
    vecs[4]  = '{"lhu",       32'h94080000, 1, 0, 0, 4'd5, 4'd0};
    vecs[5]  = '{"sw",        32'hAC080000, 0, 1, 1, 4'd0, 4'd1};
    vecs[6]  = '{"sh",        32'hA4080000, 0, 1, 1, 4'd0, 4'd2};
    vecs[7]  = '{"sb",        32'hA0080000, 0, 1, 1, 4'd0, 4'd3};
    vecs[8]  = '{"nop",       32'h00000000, 0, 0, 0, 4'd0, 4'd0};
    vecs[9]  = '{"add",       32'h01095020, 0, 0, 0, 4'd0, 4'd0};
    vecs[10] = '{"beq",       32'h1000FFFF, 0, 0, 0, 4'd0, 4'd0};
    vecs[11] = '{"mtc0",      32'h40806000, 0, 0, 0, 4'd0, 4'd0};
    vecs[12] = '{"lwl",       32'h88080000, 0, 0, 0, 4'd0, 4'd0};
    vecs[13] = '{"swl",       32'hA8080000, 0, 0, 0, 4'd0, 4'd0};
    vecs[14] = '{"lw_zero",   32'h8C000000, 1, 0, 0, 4'd1, 4'd0};
    vecs[15] = '{"lw_ones",   32'h8FFFFFFF, 1, 0, 0, 4'd1, 4'd0};
    vecs[16] = '{"lw_rand",   32'h8E5A3C71, 1, 0, 0, 4'd1, 4'd0};
    vecs[17] = '{"sw_ones",   32'hAFFFFFFF, 0, 1, 1, 4'd0, 4'd1};
    vecs[18] = '{"ones_op",   32'hFFFFFFFF, 0, 0, 0, 4'd0, 4'd0};

    // Reset held: outputs still follow instr, reset does not force them
    @(negedge clk);
    #1 check("reset_nop", 11'd0);
    instr = 32'h8C080004;
    #1 check("reset_lw", pack_exp(1, 0, 0, 4'd1, 4'd0));
    instr = 32'hA0080000;
    #1 check("reset_sb", pack_exp(0, 1, 1, 4'd0, 4'd3));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      instr = vecs[i].instr;
      #1 check(vecs[i].name, pack_exp(vecs[i].load, vecs[i].store, vecs[i].mem_write,
                                      vecs[i].dml, vecs[i].dms));
    end

    // Zero-latency: change instr mid-cycle and sample before the next edge
    @(posedge clk);
    #2 instr = 32'hAC080000;
    #1 check("midcycle_sw", pack_exp(0, 1, 1, 4'd0, 4'd1));
    instr = 32'h94080000;
    #1 check("midcycle_lhu", pack_exp(1, 0, 0, 4'd5, 4'd0));

    // All 64 opcodes with random operand bits, reset toggled while clk runs
    for (int op = 0; op < 64; op++) begin
      @(negedge clk);
      reset = op[0];
      instr = {op[5:0], 26'($urandom)};
      #1;
      check($sformatf("sweep_op%02h", op), ref_model(op[5:0]));
      check_bit("excl_load_store", load & store, 1'b0);
      check_bit("memwrite_eq_store", MemWrite, store);
    end

    reset = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Memory-instruction decoder for the MIPS pipeline's memory (M) stage.
- Takes the 32-bit instruction word held in the M stage and classifies it as load, store or neither.
- Produces the data-memory write enable, the load sub-operation code (load extract/extend) and the store sub-operation code (byte-lane merge).
- Consumed combinationally by the data-memory block and its address-exception checker in the same cycle.

Parameters:
- None.

Ports:
- clk  input  1  system clock; no internal state is clocked (port kept for interface uniformity).
- reset  input  1  synchronous, active-high reset; no effect on outputs, which are purely combinational.
- instr  input  32  instruction word; only instr[31:26] (opcode) is examined.
- MemWrite  output  1  data-memory write request; 1 for sw/sh/sb.
- DMLOp  output  4  load sub-op code (encoding below).
- DMSOp  output  4  store sub-op code (encoding below).
- load  output  1  1 when instr is lw/lb/lbu/lh/lhu.
- store  output  1  1 when instr is sw/sh/sb.

Behaviour:
- Purely combinational; zero latency. Outputs follow instr within the same cycle, with no registers.
- clk and reset are accepted but unused; reset does not force outputs (they depend only on instr).
- Opcode map (instr[31:26]):
  - lw 100011
  - lb 100000
  - lbu 100100
  - lh 100001
  - lhu 100101
  - sw 101011
  - sh 101001
  - sb 101000
- DMLOp encoding (the `_dm` define names):
  - none 4'd0
  - lw_dm 4'd1
  - lb_dm 4'd2
  - lbu_dm 4'd3
  - lh_dm 4'd4
  - lhu_dm 4'd5
  - Codes 6..15 are never produced.
- DMSOp encoding:
  - none 4'd0
  - sw_dm 4'd1
  - sh_dm 4'd2
  - sb_dm 4'd3
  - Codes 4..15 are never produced.
- load: 1 for each of the five load opcodes, else 0. When load=1, DMLOp is the matching code and DMSOp=0.
- store: 1 for each of the three store opcodes, else 0. When store=1, DMSOp is the matching code and DMLOp=0.
- MemWrite equals store exactly.
- load and store are mutually exclusive; never both 1.
- Every other opcode gives all outputs 0. This includes:
  - R-type 000000, including nop = 32'h0
  - branches, jumps, immediates
  - COP0 010000 (mfc0/mtc0/eret)
  - unimplemented opcodes such as lwl 100010 and swl 101010
- Fields other than instr[31:26] (rs, rt, offset) never affect outputs.
- Gating of MemWrite by exceptions or interrupts is done by the consumer, not here.
- The outputs carry no X for any fully defined instr.

Test Plan:
- instr=32'h8C080004 (lw) -> load=1, store=0, MemWrite=0, DMLOp=1, DMSOp=0.
- Sweep the other loads: 32'h80080000 (lb) -> DMLOp=2; 32'h90080000 (lbu) -> DMLOp=3; 32'h84080000 (lh) -> DMLOp=4; 32'h94080000 (lhu) -> DMLOp=5. Each gives load=1, store=0, MemWrite=0, DMSOp=0.
- Stores: 32'hAC080000 (sw) -> store=1, MemWrite=1, DMSOp=1, DMLOp=0, load=0; 32'hA4080000 (sh) -> DMSOp=2; 32'hA0080000 (sb) -> DMSOp=3.
- Non-memory instructions (all outputs 0):
  - 32'h00000000 (nop)
  - 32'h01095020 (add)
  - 32'h1000FFFF (beq)
  - 32'h40806000 (mtc0)
  - 32'h88080000 (lwl opcode)
- Operand independence: lw with rs/rt/offset varied over 0, all-ones and random (e.g. 32'h8FFFFFFF) -> outputs identical to the first scenario.
- Exhaustive sweep of all 64 opcodes with random low 26 bits, reset toggled and clk running -> outputs depend only on the opcode and match the map above in the same cycle; load&store never both 1; MemWrite==store throughout.
